// File: rtl/gbc_snd_pulse.sv
// Pulse (square) voice for the GBC sound engine: duty timer, length counter,
// volume envelope and optional frequency sweep driving a registered sample.
module gbc_snd_pulse #(
   parameter int HAS_SWEEP = 1,
   parameter int FREQ_W    = 11,
   parameter int LEN_W     = 6,
   parameter int VOL_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              len_tick,
   input  logic              env_tick,
   input  logic              sweep_tick,
   input  logic [2:0]        sweep_period,
   input  logic              sweep_neg,
   input  logic [2:0]        sweep_shift,
   input  logic [1:0]        duty,
   input  logic [LEN_W-1:0]  len_value,
   input  logic              len_load,
   input  logic              len_enable,
   input  logic [VOL_W-1:0]  env_init,
   input  logic              env_up,
   input  logic [2:0]        env_period,
   input  logic [FREQ_W-1:0] freq,
   input  logic              trigger,
   output logic [VOL_W-1:0]  sample,
   output logic              active,
   output logic [FREQ_W-1:0] freq_out,
   output logic              freq_wb
);
   localparam bit             SWEEP_ON = (HAS_SWEEP != 0);
   localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

   logic [FREQ_W-1:0] timer_q, timer_d;
   logic [2:0]        duty_pos_q, duty_pos_d;
   logic [LEN_W:0]    remaining_q, remaining_d;
   logic [VOL_W-1:0]  vol_q, vol_d;
   logic [2:0]        env_timer_q, env_timer_d;
   logic [FREQ_W-1:0] shadow_q, shadow_d;
   logic [3:0]        sweep_timer_q, sweep_timer_d;
   logic              sweep_en_q, sweep_en_d;
   logic              active_q, active_d;
   logic [FREQ_W-1:0] freq_out_q, freq_out_d;
   logic              freq_wb_q, freq_wb_d;
   logic [VOL_W-1:0]  sample_q, sample_d;

   logic              dac_on;
   logic [7:0]        pattern;
   logic [3:0]        sweep_reload;
   logic [FREQ_W:0]   calc_trig, calc_cur, calc_next;

   // Extra top bit of the result carries the add overflow; subtraction never sets it.
   function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] base,
                                                  input logic [2:0] shift,
                                                  input logic neg);
      logic [FREQ_W:0] delta;
      delta = {1'b0, base >> shift};
      sweep_calc = neg ? ({1'b0, base} - delta) : ({1'b0, base} + delta);
   endfunction

   assign dac_on       = (env_init != '0) | env_up;
   assign sweep_reload = (sweep_period == 3'd0) ? 4'd8 : {1'b0, sweep_period};
   assign calc_trig    = sweep_calc(freq, sweep_shift, sweep_neg);
   assign calc_cur     = sweep_calc(shadow_q, sweep_shift, sweep_neg);
   assign calc_next    = sweep_calc(calc_cur[FREQ_W-1:0], sweep_shift, sweep_neg);

   always_comb begin
      case (duty)
         2'b00:   pattern = 8'b0000_0001;
         2'b01:   pattern = 8'b1000_0001;
         2'b10:   pattern = 8'b1000_0111;
         default: pattern = 8'b0111_1110;
      endcase
   end

   always_comb begin
      timer_d       = timer_q;
      duty_pos_d    = duty_pos_q;
      remaining_d   = remaining_q;
      vol_d         = vol_q;
      env_timer_d   = env_timer_q;
      shadow_d      = shadow_q;
      sweep_timer_d = sweep_timer_q;
      sweep_en_d    = sweep_en_q;
      active_d      = active_q;
      freq_out_d    = freq_out_q;
      freq_wb_d     = 1'b0;

      if (trigger) begin
         timer_d = freq;
      end else if (ce) begin
         if (&timer_q) begin
            timer_d    = freq;
            duty_pos_d = duty_pos_q + 3'd1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end

      // A tick coinciding with a trigger still counts; the trigger then refills an empty counter.
      if (len_load) begin
         remaining_d = LEN_FULL - {1'b0, len_value};
      end else if (len_tick && len_enable && (remaining_q != '0)) begin
         remaining_d = remaining_q - 1'b1;
         if (remaining_d == '0) active_d = 1'b0;
      end
      if (trigger && (remaining_d == '0)) remaining_d = LEN_FULL;

      if (trigger) begin
         vol_d       = env_init;
         env_timer_d = env_period;
      end else if (env_tick && (env_period != 3'd0)) begin
         if (env_timer_q == 3'd1) begin
            env_timer_d = env_period;
            if (env_up && (vol_q != '1))        vol_d = vol_q + 1'b1;
            else if (!env_up && (vol_q != '0))  vol_d = vol_q - 1'b1;
         end else begin
            env_timer_d = env_timer_q - 3'd1;
         end
      end

      if (SWEEP_ON) begin
         if (trigger) begin
            shadow_d      = freq;
            sweep_timer_d = sweep_reload;
            sweep_en_d    = (sweep_period != 3'd0) | (sweep_shift != 3'd0);
         end else if (sweep_tick) begin
            if (sweep_timer_q <= 4'd1) begin
               sweep_timer_d = sweep_reload;
               if (sweep_en_q && (sweep_period != 3'd0)) begin
                  if (calc_cur[FREQ_W] && !sweep_neg) begin
                     active_d = 1'b0;
                  end else if (sweep_shift != 3'd0) begin
                     shadow_d   = calc_cur[FREQ_W-1:0];
                     freq_out_d = calc_cur[FREQ_W-1:0];
                     freq_wb_d  = 1'b1;
                     if (calc_next[FREQ_W] && !sweep_neg) active_d = 1'b0;
                  end
               end
            end else begin
               sweep_timer_d = sweep_timer_q - 4'd1;
            end
         end
      end

      if (trigger) begin
         active_d = dac_on;
         if (SWEEP_ON && (sweep_shift != 3'd0) && calc_trig[FREQ_W] && !sweep_neg) active_d = 1'b0;
      end
      if (!dac_on) active_d = 1'b0;
   end

   assign sample_d = (active_q && pattern[duty_pos_q]) ? vol_q : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_q       <= '0;
         duty_pos_q    <= '0;
         remaining_q   <= '0;
         vol_q         <= '0;
         env_timer_q   <= '0;
         shadow_q      <= '0;
         sweep_timer_q <= '0;
         sweep_en_q    <= 1'b0;
         active_q      <= 1'b0;
         freq_out_q    <= '0;
         freq_wb_q     <= 1'b0;
         sample_q      <= '0;
      end else begin
         timer_q       <= timer_d;
         duty_pos_q    <= duty_pos_d;
         remaining_q   <= remaining_d;
         vol_q         <= vol_d;
         env_timer_q   <= env_timer_d;
         shadow_q      <= shadow_d;
         sweep_timer_q <= sweep_timer_d;
         sweep_en_q    <= sweep_en_d;
         active_q      <= active_d;
         freq_out_q    <= freq_out_d;
         freq_wb_q     <= freq_wb_d;
         sample_q      <= sample_d;
      end
   end

   assign sample   = sample_q;
   assign active   = active_q;
   assign freq_out = freq_out_q;
   assign freq_wb  = freq_wb_q;
endmodule

// File: tb/tb_gbc_snd_pulse.sv
// Bench for gbc_snd_pulse: directed scenarios then random traffic, all checked
// against an event-level model of the channel rules.
module tb_gbc_snd_pulse;
   logic        clk;
   logic        reset;
   logic        ce, len_tick, env_tick, sweep_tick;
   logic [2:0]  sweep_period, sweep_shift, env_period;
   logic        sweep_neg, env_up, len_load, len_enable, trigger;
   logic [1:0]  duty;
   logic [5:0]  len_value;
   logic [3:0]  env_init;
   logic [10:0] freq;
   logic [3:0]  sample, ns_sample;
   logic        active, ns_active, freq_wb, ns_freq_wb;
   logic [10:0] freq_out, ns_freq_out;

   gbc_snd_pulse #(.HAS_SWEEP(1), .FREQ_W(11), .LEN_W(6), .VOL_W(4)) dut (
      .clk(clk), .reset(reset), .ce(ce), .len_tick(len_tick), .env_tick(env_tick),
      .sweep_tick(sweep_tick), .sweep_period(sweep_period), .sweep_neg(sweep_neg),
      .sweep_shift(sweep_shift), .duty(duty), .len_value(len_value), .len_load(len_load),
      .len_enable(len_enable), .env_init(env_init), .env_up(env_up), .env_period(env_period),
      .freq(freq), .trigger(trigger), .sample(sample), .active(active),
      .freq_out(freq_out), .freq_wb(freq_wb));

   gbc_snd_pulse #(.HAS_SWEEP(0), .FREQ_W(11), .LEN_W(6), .VOL_W(4)) dut_ns (
      .clk(clk), .reset(reset), .ce(ce), .len_tick(len_tick), .env_tick(env_tick),
      .sweep_tick(sweep_tick), .sweep_period(sweep_period), .sweep_neg(sweep_neg),
      .sweep_shift(sweep_shift), .duty(duty), .len_value(len_value), .len_load(len_load),
      .len_enable(len_enable), .env_init(env_init), .env_up(env_up), .env_period(env_period),
      .freq(freq), .trigger(trigger), .sample(ns_sample), .active(ns_active),
      .freq_out(ns_freq_out), .freq_wb(ns_freq_wb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   bit cmp_ns = 1'b0;

   // Model state: counts of events still to come rather than hardware counters.
   int m_active, m_vol, m_rem, m_pos, m_ce_left, m_env_left;
   int m_shadow, m_sw_left, m_sw_en, m_freq_out, m_wb;
   logic [7:0] pats [4] = '{8'h01, 8'h81, 8'h87, 8'h7E};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sweepValue(input int base);
      return sweep_neg ? base - (base >> sweep_shift) : base + (base >> sweep_shift);
   endfunction

   function automatic bit sweepOverflows(input int base);
      return !sweep_neg && (sweepValue(base) > 2047);
   endfunction

   task automatic modelReset();
      m_active = 0; m_vol = 0; m_rem = 0; m_pos = 0; m_ce_left = 2048; m_env_left = 0;
      m_shadow = 0; m_sw_left = 0; m_sw_en = 0; m_freq_out = 0; m_wb = 0;
   endtask

   task automatic modelEdge();
      bit dac;
      int per8;
      dac  = (env_init != 0) || env_up;
      per8 = (sweep_period == 0) ? 8 : int'(sweep_period);
      m_wb = 0;
      if (trigger) m_ce_left = 2048 - int'(freq);
      else if (ce) begin
         m_ce_left--;
         if (m_ce_left == 0) begin
            m_pos = (m_pos + 1) % 8;
            m_ce_left = 2048 - int'(freq);
         end
      end
      if (len_load) m_rem = 64 - int'(len_value);
      else if (len_tick && len_enable && m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) m_active = 0;
      end
      if (trigger && m_rem == 0) m_rem = 64;
      if (trigger) begin
         m_vol = int'(env_init);
         m_env_left = int'(env_period);
      end else if (env_tick && env_period != 0) begin
         if (m_env_left == 1) begin
            m_env_left = int'(env_period);
            if (env_up) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
            else        m_vol = (m_vol > 0) ? m_vol - 1 : 0;
         end else m_env_left = (m_env_left + 7) % 8;
      end
      if (trigger) begin
         m_shadow = int'(freq);
         m_sw_left = per8;
         m_sw_en = (sweep_period != 0) || (sweep_shift != 0);
      end else if (sweep_tick) begin
         if (m_sw_left <= 1) begin
            m_sw_left = per8;
            if (m_sw_en && sweep_period != 0) begin
               if (sweepOverflows(m_shadow)) m_active = 0;
               else if (sweep_shift != 0) begin
                  m_shadow = sweepValue(m_shadow);
                  m_freq_out = m_shadow;
                  m_wb = 1;
                  if (sweepOverflows(m_shadow)) m_active = 0;
               end
            end
         end else m_sw_left--;
      end
      if (trigger) m_active = dac && !(sweep_shift != 0 && sweepOverflows(int'(freq)));
      if (!dac) m_active = 0;
   endtask

   task automatic applyStimulus();
      int exp_sample;
      exp_sample = (m_active != 0 && pats[duty][m_pos[2:0]]) ? m_vol : 0;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("sample", 32'(sample), exp_sample);
      checkOutput("active", 32'(active), m_active);
      checkOutput("freq_wb", 32'(freq_wb), m_wb);
      checkOutput("freq_out", 32'(freq_out), m_freq_out);
      checkOutput("ns_freq_wb", 32'(ns_freq_wb), 0);
      checkOutput("ns_freq_out", 32'(ns_freq_out), 0);
      if (cmp_ns) checkOutput("ns_sample", 32'(ns_sample), exp_sample);
      trigger = 0; len_load = 0; len_tick = 0; env_tick = 0; sweep_tick = 0; ce = 0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 0; ce = 0; len_tick = 0; env_tick = 0; sweep_tick = 0; trigger = 0;
      sweep_period = 0; sweep_neg = 0; sweep_shift = 0; duty = 0; len_value = 0;
      len_load = 0; len_enable = 0; env_init = 0; env_up = 0; env_period = 0; freq = 0;
      modelReset();
      #2;
      checkOutput("rst_sample", 32'(sample), 0);
      checkOutput("rst_active", 32'(active), 0);
      checkOutput("rst_freq_out", 32'(freq_out), 0);
      checkOutput("rst_freq_wb", 32'(freq_wb), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1;

      // Duty 10 at the fastest frequency: every ce advances duty_pos.
      freq = 11'h7FF; duty = 2'b10; env_init = 4'hF; cmp_ns = 1;
      trigger = 1; applyStimulus();
      for (int i = 0; i < 16; i++) begin ce = 1; applyStimulus(); end
      applyStimulus();
      cmp_ns = 0;

      // Length 62 leaves two ticks; the third is ignored.
      len_value = 6'd62; len_load = 1; applyStimulus();
      len_enable = 1; trigger = 1; applyStimulus();
      len_tick = 1; applyStimulus();
      checkOutput("len_after_1", 32'(active), 1);
      len_tick = 1; applyStimulus();
      checkOutput("len_drop", 32'(active), 0);
      len_tick = 1; applyStimulus();
      len_enable = 0;

      // Envelope falls 2,1,0 and saturates while the channel stays on.
      env_init = 4'd2; env_period = 3'd1; trigger = 1; applyStimulus();
      for (int i = 0; i < 4; i++) begin env_tick = 1; applyStimulus(); applyStimulus(); end
      checkOutput("env_active", 32'(active), 1);

      // Sweep overflow detected at trigger time.
      env_init = 4'hF; env_period = 0; freq = 11'h700; sweep_shift = 3'd1;
      sweep_period = 3'd1; sweep_neg = 0; trigger = 1; applyStimulus();
      checkOutput("sweep_ovf_active", 32'(active), 0);
      checkOutput("ns_ovf_active", 32'(ns_active), 1);
      sweep_tick = 1; applyStimulus();
      checkOutput("sweep_ovf_no_wb", 32'(freq_wb), 0);

      // Sweep step writes back 0x180 once.
      freq = 11'h100; trigger = 1; applyStimulus();
      sweep_tick = 1; applyStimulus();
      checkOutput("sweep_freq_out", 32'(freq_out), 32'h180);
      checkOutput("sweep_wb", 32'(freq_wb), 1);
      applyStimulus();
      checkOutput("sweep_wb_single", 32'(freq_wb), 0);
      sweep_shift = 0; sweep_period = 0;

      // DAC off blocks the trigger.
      env_init = 0; env_up = 0; trigger = 1; applyStimulus();
      checkOutput("dac_off", 32'(active), 0);

      // Trigger wins over a length tick that empties the counter.
      env_init = 4'hF; len_value = 6'd63; len_load = 1; applyStimulus();
      len_enable = 1; trigger = 1; applyStimulus();
      trigger = 1; len_tick = 1; applyStimulus();
      checkOutput("trig_len_active", 32'(active), 1);
      len_tick = 1; applyStimulus();
      checkOutput("len_reloaded", 32'(active), 1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            duty = 2'($urandom); env_init = 4'($urandom); env_up = 1'($urandom);
            env_period = 3'($urandom); sweep_period = 3'($urandom);
            sweep_neg = 1'($urandom); sweep_shift = 3'($urandom);
            len_enable = 1'($urandom);
            freq = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'(12'h7E0 + 12'($urandom_range(0, 31)));
         end
         ce = ($urandom_range(0, 3) != 0);
         len_tick = ($urandom_range(0, 7) == 0);
         env_tick = ($urandom_range(0, 7) == 0);
         sweep_tick = ($urandom_range(0, 7) == 0);
         trigger = ($urandom_range(0, 29) == 0);
         len_load = ($urandom_range(0, 39) == 0);
         len_value = 6'($urandom);
         applyStimulus();
      end

      // Asynchronous reset mid-run, then restart from duty_pos 0.
      #2 reset = 0;
      #1;
      checkOutput("mid_rst_sample", 32'(sample), 0);
      checkOutput("mid_rst_active", 32'(active), 0);
      checkOutput("mid_rst_freq_out", 32'(freq_out), 0);
      modelReset();
      @(negedge clk);
      reset = 1;
      freq = 11'h7FF; duty = 2'b01; env_init = 4'h9; env_up = 0; env_period = 0;
      sweep_shift = 0; sweep_period = 0; len_enable = 0;
      trigger = 1; applyStimulus();
      applyStimulus();
      checkOutput("restart_pos0", 32'(sample), 32'h9);
      for (int i = 0; i < 10; i++) begin ce = 1; applyStimulus(); end

      $display("[TB] %0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/gbc_snd_pulse.md
# gbc_snd_pulse

Parametrised pulse (square) channel for the GBC sound engine. It generalises the square voice with compile-time sweep presence and configurable frequency, length and volume widths, so one module serves both channel 1 (sweep) and channel 2 (no sweep). It sits between the register file and the mixer:
- consumes decoded register fields, trigger/load strobes and frame-sequencer ticks;
- produces a registered amplitude sample, channel status and sweep write-back.

## Interface
- HAS_SWEEP, 1, instantiates the frequency-sweep unit (0: sweep ports ignored, freq_wb tied 0)
- FREQ_W, 11, frequency register width
- LEN_W, 6, length-load width (full length = 2^LEN_W ticks)
- VOL_W, 4, envelope volume / sample width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- ce  in  1  channel timer enable, one clk pulse at 1,048,576 Hz
- len_tick / env_tick / sweep_tick  in  1 each  frame-sequencer strobes (256/64/128 Hz), one clk wide
- sweep_period  in  3  sweep period
- sweep_neg  in  1  1 = subtract
- sweep_shift  in  3  sweep shift
- duty  in  2  duty select
- len_value  in  LEN_W  length load value
- len_load  in  1  strobe: load length
- len_enable  in  1  length counting enabled
- env_init  in  VOL_W  initial volume
- env_up  in  1  1 = increase
- env_period  in  3  envelope period
- freq  in  FREQ_W  current frequency register
- trigger  in  1  strobe: restart channel
- sample  out  VOL_W  current amplitude
- active  out  1  channel enabled (NR52 status bit)
- freq_out  out  FREQ_W  sweep result
- freq_wb  out  1  one-cycle strobe: parent writes freq_out into freq

## Operation
- Reset values: all state 0; sample=0, active=0, freq_out=0, freq_wb=0.
- dac_on = (env_init != 0) | env_up. While dac_on=0, active is forced to 0 next edge.
- Frequency timer (FREQ_W bits), advanced on ce:
  - if timer == all-ones: timer <= freq, duty_pos <= duty_pos+1 (3-bit wrap);
  - else timer+1.
- Duty patterns, bit index = duty_pos: 00 = 00000001, 01 = 10000001, 10 = 10000111, 11 = 01111110.
- Length counter (LEN_W+1 bits, remaining ticks):
  - len_load sets it to 2^LEN_W - len_value;
  - on len_tick with len_enable and remaining != 0, decrement;
  - reaching 0 clears active.
- Envelope:
  - env_tick decrements a 3-bit env_timer only when env_period != 0;
  - when env_timer is 1, reload env_period and step vol by 1 toward 2^VOL_W-1 (up) or 0 (down), saturating.
- Sweep (HAS_SWEEP=1), calc = shadow ± (shadow >> sweep_shift) in FREQ_W+1 bits; overflow = calc > 2^FREQ_W-1 (add only).
  - sweep_tick decrements sweep_timer. On reaching 0, reload with sweep_period (0 treated as 8).
  - If sweep_en and sweep_period != 0 at that reload:
    - if overflow, clear active;
    - else if shift != 0: shadow <= calc, freq_out <= calc, freq_wb pulses, then one more calc check against the new shadow; its overflow clears active (no write-back).
- Trigger (any clk, independent of ce):
  - active <= dac_on; timer <= freq; vol <= env_init; env_timer <= env_period;
  - if remaining == 0, remaining <= 2^LEN_W;
  - sweep: shadow <= freq, sweep_timer <= sweep_period (0→8), sweep_en <= (period != 0) | (shift != 0); if shift != 0, immediate overflow check (may clear active).
  - duty_pos is not reset.
- sample <= (active & pattern bit) ? vol : 0, registered.
- Priority within one cycle:
  - trigger over all ticks;
  - len_load over len_tick;
  - dac_on=0 over trigger;
  - length/sweep disable over trigger is not applied: trigger wins.
- Reset asserted mid-operation clears everything immediately (async); first trigger after release starts from duty_pos 0.

## Timing
- Trigger at edge N → active=1 after edge N; sample reflects new vol after edge N+1.
- ce step at edge N → duty_pos updated at N; sample updated at N+1.
- sweep_tick at edge N → freq_wb high for exactly the cycle after N.
- Pulse period = (2^FREQ_W - freq) × 8 ce pulses.
- No handshakes; all strobes are single-cycle and never stall.

## Test plan
- Duty: freq=0x7FF, duty=10, env_init=0xF, trigger, 16 ce → sample sequence per duty_pos 1..8 is F,F,F,0,0,0,0,F (pattern 10000111, MSB=pos 7), repeating.
- Length: len_value=62, len_enable=1, trigger → active drops exactly after 2nd len_tick; a 3rd tick is ignored.
- Envelope: env_init=2, env_up=0, env_period=1 → vol 2,1,0 on successive env_ticks, stays 0, active stays 1.
- Sweep overflow: freq=0x700, shift=1, add, period=1, trigger → immediate check 0x700+0x380 > 0x7FF, active=0, no freq_wb.
- Sweep step: freq=0x100, shift=1, period=1 → first sweep_tick gives freq_out=0x180 with one freq_wb; HAS_SWEEP=0 build never pulses freq_wb.
- DAC/priority: env_init=0, env_up=0, trigger → active stays 0; trigger coincident with len_tick at remaining=1 → active=1, remaining reloaded.
